lsu_mem_stage: RTL and testbench

- Load/store stage of the multicycle core. Sits between the execute stage and the writeback stage.
- Accepts one instruction per handshake. Performs at most one AXI4-Lite read or write transaction for it.
- Aligns and sign/zero-extends load data. Emits a single-cycle valid pulse, with the result and a passthrough bus, to writeback.
- Writeback has no backpressure. Output data is registered and held until the next completion.

---
 rtl/lsu_mem_stage.sv | 247 ++++++++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// ============================================================================
// Module  : lsu_mem_stage
// Brief   : Load/store stage; one AXI4-Lite access per instruction, load
//           alignment/extension, single-cycle completion pulse to writeback.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_mem_stage #(
    parameter int PASS_WD = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mem_ren,
    input  logic               mem_wen,
    input  logic [2:0]         funct3,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    input  logic [PASS_WD-1:0] pass_in,
    output logic               out_valid,
    output logic [31:0]        out_addr,
    output logic [31:0]        out_rdata,
    output logic [PASS_WD-1:0] pass_out,
    output logic               access_fault,
    output logic [31:0]        araddr,
    output logic               arvalid,
    input  logic               arready,
    input  logic [31:0]        rdata,
    input  logic [1:0]         rresp,
    input  logic               rvalid,
    output logic               rready,
    output logic [31:0]        awaddr,
    output logic               awvalid,
    input  logic               awready,
    output logic [31:0]        wdata_o,
    output logic [3:0]         wstrb,
    output logic               wvalid,
    input  logic               wready,
    input  logic [1:0]         bresp,
    input  logic               bvalid,
    output logic               bready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WREQ  = 3'd3,
        S_WRESP = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             r_state;
    logic [31:0]        r_addr;
    logic [2:0]         r_funct3;
    logic [PASS_WD-1:0] r_pass;
    logic               r_aw_done;
    logic               r_w_done;

    logic               r_in_ready;
    logic               r_out_valid;
    logic [31:0]        r_out_addr;
    logic [31:0]        r_out_rdata;
    logic [PASS_WD-1:0] r_pass_out;
    logic               r_fault;
    logic [31:0]        r_araddr;
    logic               r_arvalid;
    logic               r_rready;
    logic [31:0]        r_awaddr;
    logic               r_awvalid;
    logic [31:0]        r_wdata_o;
    logic [3:0]         r_wstrb;
    logic               r_wvalid;
    logic               r_bready;

    logic               w_misaligned;
    logic [3:0]         w_wstrb;
    logic [31:0]        w_lane;
    logic [31:0]        w_load_data;
    logic               w_aw_fin;
    logic               w_w_fin;

    // Alignment faults only apply to real memory accesses.
    always_comb begin
        w_misaligned = 1'b0;
        if (mem_ren || mem_wen) begin
            if ((funct3 == 3'b001 || funct3 == 3'b101) && addr[0])
                w_misaligned = 1'b1;
            if (funct3 == 3'b010 && addr[1:0] != 2'b00)
                w_misaligned = 1'b1;
        end
    end

    always_comb begin
        case (funct3[1:0])
            2'b00:   w_wstrb = 4'b0001 << addr[1:0];
            2'b01:   w_wstrb = 4'b0011 << addr[1:0];
            default: w_wstrb = 4'b1111;
        endcase
    end

    always_comb begin
        w_lane = rdata >> {r_addr[1:0], 3'b000};
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_lane[7]}},  w_lane[7:0]};
            3'b100:  w_load_data = {24'd0,            w_lane[7:0]};
            3'b001:  w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b101:  w_load_data = {16'd0,            w_lane[15:0]};
            default: w_load_data = w_lane;
        endcase
    end

    assign w_aw_fin = r_aw_done || (r_awvalid && awready);
    assign w_w_fin  = r_w_done  || (r_wvalid  && wready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_funct3    <= '0;
            r_pass      <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_rdata <= '0;
            r_pass_out  <= '0;
            r_fault     <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata_o   <= '0;
            r_wstrb     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        r_addr     <= addr;
                        r_funct3   <= funct3;
                        r_pass     <= pass_in;
                        if (w_misaligned || !(mem_ren || mem_wen)) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_out_addr  <= addr;
                            r_out_rdata <= '0;
                            r_pass_out  <= pass_in;
                            r_fault     <= w_misaligned;
                        end else if (mem_ren) begin
                            r_state   <= S_RADDR;
                            r_arvalid <= 1'b1;
                            r_araddr  <= {addr[31:2], 2'b00};
                        end else begin
                            r_state   <= S_WREQ;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_awaddr  <= {addr[31:2], 2'b00};
                            r_wdata_o <= wdata << {addr[1:0], 3'b000};
                            r_wstrb   <= w_wstrb;
                        end
                    end
                end
                S_RADDR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (rvalid) begin
                        r_rready    <= 1'b0;
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_out_addr  <= r_addr;
                        r_out_rdata <= (rresp != 2'b00) ? 32'd0 : w_load_data;
                        r_pass_out  <= r_pass;
                        r_fault     <= (rresp != 2'b00);
                    end
                end
                S_WREQ: begin
                    // Address and data channels complete independently.
                    if (r_awvalid && awready) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (r_wvalid && wready) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (bvalid) begin
                        r_bready    <= 1'b0;
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_out_addr  <= r_addr;
                        r_out_rdata <= '0;
                        r_pass_out  <= r_pass;
                        r_fault     <= (bresp != 2'b00);
                    end
                end
                S_DONE: begin
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_addr     = r_out_addr;
    assign out_rdata    = r_out_rdata;
    assign pass_out     = r_pass_out;
    assign access_fault = r_fault;
    assign araddr       = r_araddr;
    assign arvalid      = r_arvalid;
    assign rready       = r_rready;
    assign awaddr       = r_awaddr;
    assign awvalid      = r_awvalid;
    assign wdata_o      = r_wdata_o;
    assign wstrb        = r_wstrb;
    assign wvalid       = r_wvalid;
    assign bready       = r_bready;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
// ============================================================================
// Module  : tb_lsu_mem_stage
// Brief   : Scoreboard bench for lsu_mem_stage with a delay-programmable
//           AXI4-Lite slave and a behavioural load/store reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lsu_mem_stage;

    localparam int PASS_WD = 64;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               mem_ren = 1'b0;
    logic               mem_wen = 1'b0;
    logic [2:0]         funct3 = '0;
    logic [31:0]        addr = '0;
    logic [31:0]        wdata = '0;
    logic [PASS_WD-1:0] pass_in = '0;
    logic               out_valid;
    logic [31:0]        out_addr;
    logic [31:0]        out_rdata;
    logic [PASS_WD-1:0] pass_out;
    logic               access_fault;
    logic [31:0]        araddr;
    logic               arvalid;
    logic               arready = 1'b0;
    logic [31:0]        rdata = '0;
    logic [1:0]         rresp = '0;
    logic               rvalid = 1'b0;
    logic               rready;
    logic [31:0]        awaddr;
    logic               awvalid;
    logic               awready = 1'b0;
    logic [31:0]        wdata_o;
    logic [3:0]         wstrb;
    logic               wvalid;
    logic               wready = 1'b0;
    logic [1:0]         bresp = '0;
    logic               bvalid = 1'b0;
    logic               bready;

    lsu_mem_stage #(.PASS_WD(PASS_WD)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .funct3(funct3),
        .addr(addr), .wdata(wdata), .pass_in(pass_in),
        .out_valid(out_valid), .out_addr(out_addr), .out_rdata(out_rdata),
        .pass_out(pass_out), .access_fault(access_fault),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata_o(wdata_o), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0]        addr;
        logic [31:0]        rdata;
        logic [PASS_WD-1:0] pass;
        logic               fault;
        int                 cyc;
    } exp_t;

    exp_t sb[$];

    // Slave programming and expected bus requests for the instruction in flight.
    int          s_ard, s_rd, s_awd, s_wd, s_bd;
    int          exp_kind;
    logic [31:0] exp_araddr, exp_awaddr, exp_wdata;
    logic [3:0]  exp_wstrb;
    bit          aw_hs;

    function automatic logic [31:0] load_model(input logic [31:0] d, input logic [1:0] off,
                                               input logic [2:0] f3);
        logic [31:0] lane;
        int          v;
        lane = d >> (8 * off);
        case (f3)
            3'b000: begin v = int'(lane & 32'hFF);   if (v >= 128)   v -= 256;   return 32'(v); end
            3'b100: return lane & 32'hFF;
            3'b001: begin v = int'(lane & 32'hFFFF); if (v >= 32768) v -= 65536; return 32'(v); end
            3'b101: return lane & 32'hFFFF;
            default: return lane;
        endcase
    endfunction

    function automatic bit misaligned(input bit ren, input bit wen, input logic [2:0] f3,
                                      input logic [1:0] off);
        if (!(ren || wen)) return 1'b0;
        if ((f3 == 3'b001 || f3 == 3'b101) && off[0]) return 1'b1;
        if (f3 == 3'b010 && off != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    // AXI4-Lite slave: each ready/valid rises after its programmed delay.
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        end else begin
            if (arvalid) begin
                ar_cnt++;
                if (ar_cnt == 1) chk("ar_expected", 64'(exp_kind == 1), 64'd1);
            end else ar_cnt = 0;
            arready = arvalid && (ar_cnt > s_ard);
            if (arvalid && arready) chk("araddr", 64'(araddr), 64'(exp_araddr));

            if (rready) r_cnt++; else r_cnt = 0;
            rvalid = rready && (r_cnt > s_rd);

            if (awvalid) begin
                aw_cnt++;
                if (aw_cnt == 1) chk("aw_expected", 64'(exp_kind == 2), 64'd1);
            end else aw_cnt = 0;
            awready = awvalid && (aw_cnt > s_awd);
            if (awvalid && awready) begin
                chk("awaddr", 64'(awaddr), 64'(exp_awaddr));
                aw_hs = 1'b1;
            end

            if (wvalid) w_cnt++; else w_cnt = 0;
            wready = wvalid && (w_cnt > s_wd);
            if (wvalid && wready) begin
                chk("wdata_o", 64'(wdata_o), 64'(exp_wdata));
                chk("wstrb", 64'(wstrb), 64'(exp_wstrb));
            end

            if (bready) begin
                b_cnt++;
                if (b_cnt == 1) chk("bready_after_aw", 64'(aw_hs), 64'd1);
            end else b_cnt = 0;
            bvalid = bready && (b_cnt > s_bd);
        end
    end

    // Monitor: every completion pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("latency", 64'(cyc), 64'(e.cyc));
                chk("out_addr", 64'(out_addr), 64'(e.addr));
                chk("out_rdata", 64'(out_rdata), 64'(e.rdata));
                chk("pass_out", pass_out, e.pass);
                chk("access_fault", 64'(access_fault), 64'(e.fault));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            $display("FAIL in_ready_timeout actual=0 expected=1");
            n_checks++; n_fail++;
            $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
            $fatal(1, "in_ready never rose");
        end
    endtask

    task automatic issue(input bit ren, input bit wen, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [63:0] p,
                         input logic [31:0] rd, input logic [1:0] rr, input logic [1:0] br,
                         input int ard, input int rdd, input int awd, input int wdd, input int bd);
        exp_t        e;
        logic [1:0]  off;
        bit          mis;
        int          lat;
        wait_ready();
        off = a[1:0];
        mis = misaligned(ren, wen, f3, off);
        s_ard = ard; s_rd = rdd; s_awd = awd; s_wd = wdd; s_bd = bd;
        rdata = rd; rresp = rr; bresp = br;
        aw_hs = 1'b0;
        exp_araddr = a & 32'hFFFF_FFFC;
        exp_awaddr = a & 32'hFFFF_FFFC;
        exp_wdata  = wd << (8 * off);
        if (f3[1:0] == 2'b00)      exp_wstrb = 4'(1 << off);
        else if (f3[1:0] == 2'b01) exp_wstrb = 4'(3 << off);
        else                       exp_wstrb = 4'hF;
        e.addr = a;
        e.pass = p;
        e.rdata = 32'd0;
        e.fault = 1'b0;
        if (mis) begin
            exp_kind = 0; e.fault = 1'b1; lat = 1;
        end else if (ren) begin
            exp_kind = 1;
            e.fault = (rr != 2'b00);
            e.rdata = e.fault ? 32'd0 : load_model(rd, off, f3);
            lat = 3 + ard + rdd;
        end else if (wen) begin
            exp_kind = 2;
            e.fault = (br != 2'b00);
            lat = 3 + ((awd > wdd) ? awd : wdd) + bd;
        end else begin
            exp_kind = 0; lat = 1;
        end
        e.cyc = cyc + lat;
        sb.push_back(e);
        in_valid = 1'b1; mem_ren = ren; mem_wen = wen; funct3 = f3;
        addr = a; wdata = wd; pass_in = p;
        @(negedge clk);
        in_valid = 1'b0;
        mem_ren = $urandom_range(0, 1);
        mem_wen = $urandom_range(0, 1);
        addr = $urandom;
    endtask

    initial begin
        logic [2:0] f3_tab [5];
        f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
        f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;
        s_ard = 0; s_rd = 0; s_awd = 0; s_wd = 0; s_bd = 0; exp_kind = 0;
        exp_araddr = '0; exp_awaddr = '0; exp_wdata = '0; exp_wstrb = '0; aw_hs = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_rdata", 64'(out_rdata), 64'd0);
        chk("rst_axi_valids", 64'({arvalid, rready, awvalid, wvalid, bready}), 64'd0);
        chk("rst_fault", 64'(access_fault), 64'd0);
        rst = 1'b0;

        issue(0, 0, 3'b000, 32'h0000_0040, 32'd0, 64'h1234, 32'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0);
        issue(1, 0, 3'b000, 32'h8000_0003, 32'd0, 64'h11, 32'h80FF_1122, 2'd0, 2'd0, 0, 0, 0, 0, 0);
        issue(1, 0, 3'b100, 32'h8000_0003, 32'd0, 64'h12, 32'h80FF_1122, 2'd0, 2'd0, 1, 2, 0, 0, 0);
        issue(0, 1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 64'h13, 32'd0, 2'd0, 2'd0, 0, 0, 3, 0, 0);
        issue(1, 0, 3'b010, 32'h8000_0002, 32'd0, 64'h14, 32'h1234_5678, 2'd0, 2'd0, 0, 0, 0, 0, 0);
        issue(0, 1, 3'b010, 32'h8000_0010, 32'hCAFE_F00D, 64'h15, 32'd0, 2'd0, 2'b10, 0, 2, 0, 0, 1);
        issue(1, 0, 3'b010, 32'h8000_0014, 32'd0, 64'h16, 32'hDEAD_BEEF, 2'd0, 2'd0, 0, 0, 0, 0, 0);
        issue(1, 1, 3'b101, 32'h0000_0102, 32'hFFFF, 64'h17, 32'h9ABC_DEF0, 2'd0, 2'd0, 0, 1, 0, 0, 0);

        // Reset while waiting for read data, then confirm a clean restart.
        issue(1, 0, 3'b010, 32'h8000_0020, 32'd0, 64'h18, 32'h0, 2'd0, 2'd0, 0, 40, 0, 0, 0);
        repeat (4) @(negedge clk);
        chk("pre_rst_rready", 64'(rready), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        chk("async_rst_rready", 64'(rready), 64'd0);
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        issue(1, 0, 3'b001, 32'h8000_0022, 32'd0, 64'h19, 32'h8001_7FFF, 2'd0, 2'd0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            int op;
            op = $urandom_range(0, 4);
            issue(op == 1 || op == 3, op == 2 || op == 3, f3_tab[$urandom_range(0, 4)],
                  $urandom, $urandom, {$urandom, $urandom}, $urandom,
                  ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00,
                  ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
        end

        for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
